// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared 7-segment constants and the active-low hex encoding table.
package hex_disp_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if: data/load/blank inputs and segment/anode outputs of the scanner.
interface hex_display_scanner_if #(parameter int DIGITS = 8);
    logic [4*DIGITS-1:0] data_i;
    logic                load_i;
    logic [DIGITS-1:0]   blank_i;
    logic [6:0]          hex_o;
    logic [DIGITS-1:0]   an_o;
    modport master (output data_i, load_i, blank_i, input hex_o, an_o);
    modport slave  (input data_i, load_i, blank_i, output hex_o, an_o);
endinterface

// File: rtl/hex_seg_encoder.sv
// hex_seg_encoder: combinational nibble to active-low {g,f,e,d,c,b,a} segments.
module hex_seg_encoder
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = seg_encode(nibble);
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed common-anode 7-segment scanner with registered outputs.
// Optional leading-zero suppression when HEX_LZ_BLANK_EN is defined.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 50000
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    hex_display_scanner_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [DW-1:0]            div_cnt;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0][3:0]   sh_data;
    logic [DIGITS-1:0]        sh_blank;
    logic [DIGITS-1:0]        lz;
    logic [DIGITS-1:0]        blank_eff;
    logic [6:0]               seg;
    logic                     tick;

    assign tick = div_cnt == DW'(CLK_DIV - 1);

`ifdef HEX_LZ_BLANK_EN
    // Walk from the most significant digit down while all nibbles seen so far are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (sh_data[k] == 4'h0);
            lz[k] = (k != 0) && zero_run;
        end
    end
`else
    assign lz = '0;
`endif

    assign blank_eff = sh_blank | lz;

    hex_seg_encoder u_enc (.nibble(sh_data[idx]), .seg(seg));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt    <= '0;
            idx        <= '0;
            sh_data    <= '0;
            sh_blank   <= '0;
            bus.hex_o  <= SEG_OFF;
            bus.an_o   <= '1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            if (bus.load_i) begin
                sh_data  <= bus.data_i;
                sh_blank <= bus.blank_i;
            end
            bus.hex_o <= blank_eff[idx] ? SEG_OFF : seg;
            bus.an_o  <= blank_eff[idx] ? '1 : ~(DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed stimulus with a cycle model feeding an expected-output queue.
module tb_hex_display_scanner;
    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_display_scanner_if #(.DIGITS(DIGITS)) bus ();
    hex_display_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [6:0] lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q [$];

    int          m_div;
    int          m_idx;
    logic [15:0] m_data;
    logic [3:0]  m_blank;

    function automatic logic [10:0] predict();
        logic blk;
        if (rst) return {7'h7F, 4'hF};
        blk = m_blank[m_idx];
`ifdef HEX_LZ_BLANK_EN
        if (m_idx != 0 && (m_data >> (4 * m_idx)) == 16'h0) blk = 1'b1;
`endif
        if (blk) return {7'h7F, 4'hF};
        return {lut[m_data[4*m_idx +: 4]], ~(4'b0001 << m_idx)};
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag);
        logic [10:0] e;
        exp_q.push_back(predict());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {bus.hex_o, bus.an_o}, e);
        if (rst) begin
            m_div = 0; m_idx = 0; m_data = '0; m_blank = '0;
        end else begin
            if (bus.load_i) begin
                m_data  = bus.data_i;
                m_blank = bus.blank_i;
            end
            if (m_div == CLK_DIV - 1) begin
                m_div = 0;
                m_idx = (m_idx + 1) % DIGITS;
            end else m_div++;
        end
    endtask

    initial begin
        bus.data_i = '0; bus.load_i = 1'b0; bus.blank_i = '0;
        m_div = 0; m_idx = 0; m_data = '0; m_blank = '0;
        // Reset, then first slot shows digit 0 holding zero
        rst = 1'b1;
        step("reset0"); step("reset1");
        check("reset_const", {bus.hex_o, bus.an_o}, {7'h7F, 4'hF});
        rst = 1'b0;
        step("first_slot");
        check("first_slot_const", {bus.hex_o, bus.an_o}, {7'h40, 4'hE});
        repeat (3) step("slot0");
        // Scan with 1A3F
        bus.data_i = 16'h1A3F; bus.load_i = 1'b1;
        step("scan_load");
        bus.load_i = 1'b0;
        repeat (40) step("scan");
        // Blank mask on digits 0 and 2
        bus.data_i = 16'h1234; bus.blank_i = 4'b0101; bus.load_i = 1'b1;
        step("blank_load");
        bus.load_i = 1'b0; bus.blank_i = '0;
        repeat (32) step("blank");
        // Load mid-slot at div_cnt == 2
        bus.data_i = 16'h0000; bus.load_i = 1'b1;
        step("mid_load0");
        bus.load_i = 1'b0;
        for (int i = 0; i < 2 * CLK_DIV && m_div != 2; i++) step("mid_align");
        check("mid_aligned", {7'h0, 4'(m_div)}, {7'h0, 4'd2});
        bus.data_i = 16'hFFFF; bus.load_i = 1'b1;
        step("mid_load");
        bus.load_i = 1'b0;
        repeat (20) step("mid_after");
        // Reset mid-scan at idx 2
        for (int i = 0; i < 4 * DIGITS * CLK_DIV && !(m_idx == 2 && m_div == 1); i++) step("rst_align");
        check("rst_aligned", {7'h0, 4'(m_idx)}, {7'h0, 4'd2});
        rst = 1'b1;
        step("midrst0"); step("midrst1");
        check("midrst_const", {bus.hex_o, bus.an_o}, {7'h7F, 4'hF});
        rst = 1'b0;
        repeat (20) step("after_rst");
        // Leading zeros (suppressed only when the feature macro is defined)
        bus.data_i = 16'h0050; bus.load_i = 1'b1;
        step("lz_load");
        bus.load_i = 1'b0;
        repeat (20) step("lz_0050");
        bus.data_i = 16'h0000; bus.load_i = 1'b1;
        step("lz_load0");
        bus.load_i = 1'b0;
        repeat (20) step("lz_0000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
